// File: rtl/mul_iterative_unit_pkg.sv
// Shared opcode constants, FSM state and operation types for the iterative multiplier.
// The ALU_* encodings are the ones the instruction decoder drives on ALUControl.
package mul_iterative_unit_pkg;

  localparam logic [3:0] ALU_MUL   = 4'b0100;
  localparam logic [3:0] ALU_UMULL = 4'b0110;
  localparam logic [3:0] ALU_SMULL = 4'b1000;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    OpMul,
    OpUmull,
    OpSmull
  } op_e;

  function automatic logic op_legal(input logic [3:0] ctrl);
    return (ctrl == ALU_MUL) || (ctrl == ALU_UMULL) || (ctrl == ALU_SMULL);
  endfunction

  // Illegal encodings map to OpMul; callers gate on op_legal() first.
  function automatic op_e op_decode(input logic [3:0] ctrl);
    op_e op;
    case (ctrl)
      ALU_UMULL: op = OpUmull;
      ALU_SMULL: op = OpSmull;
      default:   op = OpMul;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mul_iterative_unit_if.sv
// Request/response bundle between the decode FSM (master) and the multiplier (slave).
interface mul_iterative_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ResultLo;
  logic [WIDTH-1:0] ResultHi;
  logic [1:0]       FlagsNZ;

  modport master (
    output start, ALUControl, SrcA, SrcB,
    input  busy, done, ResultLo, ResultHi, FlagsNZ
  );

  modport slave (
    input  start, ALUControl, SrcA, SrcB,
    output busy, done, ResultLo, ResultHi, FlagsNZ
  );

endinterface

// File: rtl/mul_iterative_unit_shift_add_core.sv
// Unsigned shift-add datapath: one multiplier bit per step, LSB first.
// After WIDTH steps {acc, mplier} holds the full 2*WIDTH-bit product.
module mul_iterative_unit_shift_add_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               last_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      // Shift {carry, acc, mplier} right by one; retired multiplier bits make room
      // for the low half of the product.
      acc_d    = sum[WIDTH:1];
      mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
      cnt_d    = last_o ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign last_o    = (cnt_q == CntLast);
  assign product_o = {acc_q, mplier_q};

endmodule

// File: rtl/mul_iterative_unit.sv
// Multicycle MUL/UMULL/SMULL unit: FSM, sign handling and result/flag registers
// around an unsigned shift-add core. Signed operands are multiplied as magnitudes.
module mul_iterative_unit
  import mul_iterative_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic                 clk,
  input logic                 reset,
  mul_iterative_unit_if.slave bus
);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  logic   sign_q, sign_d;

  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [1:0]       flags_q, flags_d;

  logic               accept;
  logic               smull_req;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] core_product;
  logic [2*WIDTH-1:0] fixed_product;
  logic               core_last;

  // Requests are only sampled when no operation is in flight.
  always_comb begin
    smull_req = (bus.ALUControl == ALU_SMULL);
    accept    = bus.start && op_legal(bus.ALUControl) &&
                ((state_q == StIdle) || (state_q == StDone));
    // 0x80..0 negates to itself, which read unsigned is exactly 2^(WIDTH-1).
    mag_a     = (smull_req && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
    mag_b     = (smull_req && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;
  end

  mul_iterative_unit_shift_add_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk_i     (clk),
    .reset_i   (reset),
    .load_i    (accept),
    .step_i    (state_q == StRun),
    .mcand_i   (mag_a),
    .mplier_i  (mag_b),
    .product_o (core_product),
    .last_o    (core_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StRun;
      StRun:  if (core_last) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_d   = op_q;
    sign_d = sign_q;
    if (accept) begin
      op_d   = op_decode(bus.ALUControl);
      sign_d = smull_req && (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
    end
  end

  always_comb begin
    fixed_product = sign_q ? -core_product : core_product;
    res_lo_d      = res_lo_q;
    res_hi_d      = res_hi_q;
    flags_d       = flags_q;
    if (state_q == StFix) begin
      res_lo_d = fixed_product[WIDTH-1:0];
      if (op_q == OpMul) begin
        res_hi_d = '0;
        flags_d  = {fixed_product[WIDTH-1], fixed_product[WIDTH-1:0] == '0};
      end else begin
        res_hi_d = fixed_product[2*WIDTH-1:WIDTH];
        flags_d  = {fixed_product[2*WIDTH-1], fixed_product == '0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      sign_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    bus.busy     = (state_q == StRun) || (state_q == StFix);
    bus.done     = (state_q == StDone);
    bus.ResultLo = res_lo_q;
    bus.ResultHi = res_hi_q;
    bus.FlagsNZ  = flags_q;
  end

endmodule

// File: tb/tb_mul_iterative_unit.sv
// Self-checking bench for mul_iterative_unit: directed vectors, random operations
// against an arithmetic reference, and hand-written multi-cycle corner sequences.
module tb_mul_iterative_unit;
  import mul_iterative_unit_pkg::*;

  localparam int unsigned W = 32;
  localparam int Latency = W + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_iterative_unit_if #(.WIDTH(W)) bus ();

  mul_iterative_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  nz;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference computed from plain arithmetic on the architectural operation.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] hi,
                                output logic [31:0] lo, output logic [1:0] nz);
    logic [63:0] p;
    logic [31:0] m;
    if (op == ALU_MUL) begin
      m  = a * b;
      hi = 32'h0;
      lo = m;
      nz = {lo[31], lo == 32'h0};
    end else begin
      if (op == ALU_UMULL) p = {32'h0, a} * {32'h0, b};
      else p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      hi = p[63:32];
      lo = p[31:0];
      nz = {hi[31], p == 64'h0};
    end
  endfunction

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start      = 1'b1;
    bus.ALUControl = op;
    bus.SrcA       = a;
    bus.SrcB       = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after the accepting one until done; 0 if the bound expires.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= Latency + 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic exec(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                      input logic [1:0] enz);
    int n;
    issue(op, a, b);
    check({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
    wait_done(n);
    check({tag, " latency"}, 64'(n), 64'(Latency));
    check({tag, " hi"}, 64'(bus.ResultHi), 64'(ehi));
    check({tag, " lo"}, 64'(bus.ResultLo), 64'(elo));
    check({tag, " nz"}, 64'(bus.FlagsNZ), 64'(enz));
    check({tag, " busy_in_done"}, 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
    check({tag, " hi_held"}, 64'(bus.ResultHi), 64'(ehi));
  endtask

  task automatic count_dones(input int cycles, output int dones, output int busies);
    dones  = 0;
    busies = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
      if (bus.busy) busies++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    logic [31:0] ehi, elo;
    logic [1:0]  enz;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          n, dones, busies;

    vecs[0] = '{ALU_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2'b10};
    vecs[1] = '{ALU_SMULL, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2'b10};
    vecs[2] = '{ALU_SMULL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2'b00};
    vecs[3] = '{ALU_MUL,   32'd7,         32'd6,         32'h0,         32'd42,        2'b00};
    vecs[4] = '{ALU_MUL,   32'h0001_0000, 32'h0001_0000, 32'h0,         32'h0,         2'b01};
    vecs[5] = '{ALU_UMULL, 32'h0,         32'd12345,     32'h0,         32'h0,         2'b01};
    vecs[6] = '{ALU_SMULL, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 2'b10};
    vecs[7] = '{ALU_MUL,   32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF, 2'b10};

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.ALUControl = 4'h0;
    bus.SrcA       = '0;
    bus.SrcB       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset lo", 64'(bus.ResultLo), 64'd0);
    check("reset hi", 64'(bus.ResultHi), 64'd0);
    check("reset nz", 64'(bus.FlagsNZ), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      exec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
           vecs[i].hi, vecs[i].lo, vecs[i].nz);
    end

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0:       rop = ALU_MUL;
        1:       rop = ALU_UMULL;
        default: rop = ALU_SMULL;
      endcase
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        2:       ra = 32'h0;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      model(rop, ra, rb, ehi, elo, enz);
      exec($sformatf("rand%0d op=%0h a=%0h b=%0h", i, rop, ra, rb), rop, ra, rb, ehi, elo, enz);
    end

    // start while busy is ignored and operands stay latched
    issue(ALU_UMULL, 32'd3, 32'd4);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.start      = 1'b1;
    bus.ALUControl = ALU_MUL;
    bus.SrcA       = 32'd5;
    bus.SrcB       = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    count_dones(40, dones, busies);
    check("midrun done_count", 64'(dones), 64'd1);
    check("midrun lo", 64'(bus.ResultLo), 64'd12);
    check("midrun hi", 64'(bus.ResultHi), 64'd0);

    // back-to-back: start presented in the DONE cycle
    issue(ALU_UMULL, 32'd7, 32'd9);
    wait_done(n);
    check("b2b first latency", 64'(n), 64'(Latency));
    check("b2b first lo", 64'(bus.ResultLo), 64'd63);
    issue(ALU_UMULL, 32'd2, 32'd3);
    check("b2b done_dropped", 64'(bus.done), 64'd0);
    check("b2b busy_rose", 64'(bus.busy), 64'd1);
    check("b2b lo_held", 64'(bus.ResultLo), 64'd63);
    wait_done(n);
    check("b2b second latency", 64'(n), 64'(Latency));
    check("b2b second lo", 64'(bus.ResultLo), 64'd6);
    @(posedge clk);
    #1;

    // illegal opcode is ignored entirely
    issue(4'b0000, 32'd9, 32'd9);
    check("illegal busy", 64'(bus.busy), 64'd0);
    count_dones(40, dones, busies);
    check("illegal done_count", 64'(dones), 64'd0);
    check("illegal busy_count", 64'(busies), 64'd0);
    check("illegal lo_held", 64'(bus.ResultLo), 64'd6);

    // reset part-way through RUN aborts the operation
    issue(ALU_SMULL, 32'hFFFF_FFFB, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("abort busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    check("abort lo", 64'(bus.ResultLo), 64'd0);
    check("abort hi", 64'(bus.ResultHi), 64'd0);
    check("abort nz", 64'(bus.FlagsNZ), 64'd0);
    count_dones(40, dones, busies);
    check("abort done_count", 64'(dones), 64'd0);

    // unit is usable again after the abort
    exec("post_abort", ALU_SMULL, 32'hFFFF_FFFB, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFDD, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
